// File: rtl/pll_lock_mgr.sv
// PLL lock manager: per-channel reset pulse, lock filter, timeout and retry.
// Ports: sys_clk/sys_rst_n, pll_lock, clear_fail in; pll_rst, ch_ready, ch_fail, all_ready, retry_cnt out.
module pll_lock_mgr #(
  parameter int N_PLL        = 2,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_FILT    = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [N_PLL-1:0]   pll_lock,
  input  logic [N_PLL-1:0]   clear_fail,
  output logic [N_PLL-1:0]   pll_rst,
  output logic [N_PLL-1:0]   ch_ready,
  output logic [N_PLL-1:0]   ch_fail,
  output logic               all_ready,
  output logic [4*N_PLL-1:0] retry_cnt
);

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam int FCW = $clog2(LOCK_FILT + 1);
  localparam int TCW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYCLES - 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(LOCK_FILT - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]     RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RST,
    S_WAIT,
    S_FILT,
    S_LOCKED,
    S_FAIL
  } state_t;

  logic [N_PLL-1:0] sync_q;
  logic [N_PLL-1:0] lock_s;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
      lock_s <= '0;
    end else begin
      sync_q <= pll_lock;
      lock_s <= sync_q;
    end
  end

  for (genvar i = 0; i < N_PLL; i++) begin : g_ch
    state_t         state_q, state_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic [3:0]     retry_q, retry_d;
    logic           tmo;
    logic           fail_evt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state_q <= S_RST;
        rcnt_q  <= '0;
        fcnt_q  <= '0;
        tcnt_q  <= '0;
        retry_q <= '0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
        fcnt_q  <= fcnt_d;
        tcnt_q  <= tcnt_d;
        retry_q <= retry_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      rcnt_d   = rcnt_q;
      fcnt_d   = fcnt_q;
      tcnt_d   = tcnt_q;
      retry_d  = retry_q;
      fail_evt = 1'b0;
      tmo      = (tcnt_q == TMO_LAST);
      unique case (state_q)
        S_RST: begin
          if (rcnt_q == RST_LAST) begin
            state_d = S_WAIT;
            rcnt_d  = '0;
            fcnt_d  = '0;
            tcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          // timeout wins over a lock seen on the same cycle
          if (tmo) begin
            fail_evt = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
            fcnt_d = '0;
            if (lock_s[i]) state_d = S_FILT;
          end
        end
        S_FILT: begin
          if (tmo) begin
            fail_evt = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
            if (!lock_s[i]) begin
              state_d = S_WAIT;
              fcnt_d  = '0;
            end else if (fcnt_q == FILT_LAST) begin
              state_d = S_LOCKED;
              fcnt_d  = '0;
            end else begin
              fcnt_d = fcnt_q + 1'b1;
            end
          end
        end
        S_LOCKED: begin
          if (!lock_s[i]) fail_evt = 1'b1;
        end
        S_FAIL: begin
          if (clear_fail[i]) begin
            state_d = S_RST;
            rcnt_d  = '0;
            retry_d = '0;
          end
        end
        default: state_d = S_RST;
      endcase
      if (fail_evt) begin
        rcnt_d = '0;
        fcnt_d = '0;
        tcnt_d = '0;
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          state_d = S_RST;
        end else begin
          state_d = S_FAIL;
        end
      end
    end

    assign pll_rst[i]        = (state_q == S_RST) || (state_q == S_FAIL);
    assign ch_ready[i]       = (state_q == S_LOCKED);
    assign ch_fail[i]        = (state_q == S_FAIL);
    assign retry_cnt[4*i+:4] = retry_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) all_ready <= 1'b0;
    else            all_ready <= &ch_ready;
  end

endmodule

// File: tb/tb_pll_lock_mgr.sv
// Directed bench for pll_lock_mgr: lock, glitch, loss, timeout/fail, clear, async reset.
// Cycle numbers count sys_clk edges after reset release; outputs sampled 1 ns after the edge.
module tb_pll_lock_mgr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] pll_lock = 2'b00;
  logic [1:0] clear_fail = 2'b00;
  logic [1:0] pll_rst;
  logic [1:0] ch_ready;
  logic [1:0] ch_fail;
  logic       all_ready;
  logic [7:0] retry_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  pll_lock_mgr #(
    .N_PLL(2),
    .RST_CYCLES(4),
    .LOCK_FILT(8),
    .LOCK_TIMEOUT(64),
    .MAX_RETRY(2)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .pll_lock(pll_lock),
    .clear_fail(clear_fail),
    .pll_rst(pll_rst),
    .ch_ready(ch_ready),
    .ch_fail(ch_fail),
    .all_ready(all_ready),
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk_rst_vals(input string tag);
    check({tag, "_pll_rst"}, 8'(pll_rst), 8'h03);
    check({tag, "_ready"}, 8'(ch_ready), 8'h00);
    check({tag, "_fail"}, 8'(ch_fail), 8'h00);
    check({tag, "_all"}, 8'(all_ready), 8'h00);
    check({tag, "_retry"}, retry_cnt, 8'h00);
  endtask

  task automatic restart(input logic [1:0] lk);
    rst_n = 1'b0;
    pll_lock = lk;
    clear_fail = 2'b00;
    tick();
    tick();
    chk_rst_vals("rst");
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #1;
    chk_rst_vals("por");

    // clean lock: RST edges 1..3, WAIT at 4, FILT at 5, LOCKED at 13
    restart(2'b11);
    run_to(3);
    check("clean_rst_hi", 8'(pll_rst), 8'h03);
    run_to(4);
    check("clean_rst_lo", 8'(pll_rst), 8'h00);
    run_to(12);
    check("clean_rdy_early", 8'(ch_ready), 8'h00);
    run_to(13);
    check("clean_rdy", 8'(ch_ready), 8'h03);
    check("clean_all_lag", 8'(all_ready), 8'h00);
    run_to(14);
    check("clean_all", 8'(all_ready), 8'h01);
    check("clean_retry", retry_cnt, 8'h00);

    // glitch: lock_s[0] low for the edge-11 decision (5 filter counts done)
    // -> WAIT at 11, FILT at 12, LOCKED at 20
    restart(2'b11);
    run_to(8);
    pll_lock = 2'b10;
    run_to(9);
    pll_lock = 2'b11;
    run_to(13);
    check("glitch_ch1_only", 8'(ch_ready), 8'h02);
    run_to(19);
    check("glitch_rdy_early", 8'(ch_ready), 8'h02);
    run_to(20);
    check("glitch_rdy", 8'(ch_ready), 8'h03);
    check("glitch_retry", retry_cnt, 8'h00);
    run_to(21);
    check("glitch_all", 8'(all_ready), 8'h01);

    // lock loss on ch1: lock_s[1] low at edge 24 -> RST 24..27, WAIT 28
    pll_lock = 2'b01;
    run_to(23);
    check("loss_rdy_hold", 8'(ch_ready), 8'h03);
    run_to(24);
    check("loss_rdy", 8'(ch_ready), 8'h01);
    check("loss_retry", retry_cnt, 8'h10);
    check("loss_pll_rst", 8'(pll_rst), 8'h02);
    pll_lock = 2'b11;
    run_to(25);
    check("loss_all", 8'(all_ready), 8'h00);
    run_to(27);
    check("loss_rst_end", 8'(pll_rst), 8'h02);
    run_to(28);
    check("loss_rst_off", 8'(pll_rst), 8'h00);
    run_to(36);
    check("relock_early", 8'(ch_ready), 8'h01);
    run_to(37);
    check("relock_rdy", 8'(ch_ready), 8'h03);
    check("relock_retry", retry_cnt, 8'h10);

    // timeout: WAIT at 4, timeouts at 68, 136, 204 (last one -> FAIL)
    restart(2'b10);
    run_to(67);
    check("tmo_pre", 8'(pll_rst), 8'h00);
    check("tmo_pre_retry", retry_cnt, 8'h00);
    run_to(68);
    check("tmo1_rst", 8'(pll_rst), 8'h01);
    check("tmo1_retry", retry_cnt, 8'h01);
    run_to(71);
    check("tmo1_rst_end", 8'(pll_rst), 8'h01);
    run_to(72);
    check("tmo1_rst_off", 8'(pll_rst), 8'h00);
    run_to(135);
    check("tmo2_pre", retry_cnt, 8'h01);
    run_to(136);
    check("tmo2_retry", retry_cnt, 8'h02);
    check("tmo2_rst", 8'(pll_rst), 8'h01);
    run_to(203);
    check("tmo3_pre", 8'(ch_fail), 8'h00);
    run_to(204);
    check("fail_flag", 8'(ch_fail), 8'h01);
    check("fail_pll_rst", 8'(pll_rst), 8'h01);
    check("fail_retry", retry_cnt, 8'h02);
    check("fail_ch1_ok", 8'(ch_ready), 8'h02);
    pll_lock = 2'b11;
    run_to(214);
    check("fail_hold", 8'(ch_fail), 8'h01);
    check("fail_hold_rst", 8'(pll_rst), 8'h01);
    check("fail_hold_rdy", 8'(ch_ready), 8'h02);

    // clear_fail[1] in LOCKED is ignored; clear_fail[0] at edge 216
    clear_fail = 2'b10;
    run_to(215);
    clear_fail = 2'b00;
    check("clr1_fail", 8'(ch_fail), 8'h01);
    check("clr1_rdy", 8'(ch_ready), 8'h02);
    clear_fail = 2'b01;
    run_to(216);
    clear_fail = 2'b00;
    check("clr0_fail", 8'(ch_fail), 8'h00);
    check("clr0_retry", retry_cnt, 8'h00);
    check("clr0_rst", 8'(pll_rst), 8'h01);
    run_to(219);
    check("clr0_rst_end", 8'(pll_rst), 8'h01);
    run_to(220);
    check("clr0_rst_off", 8'(pll_rst), 8'h00);
    run_to(228);
    check("clr0_rdy_early", 8'(ch_ready), 8'h02);
    run_to(229);
    check("clr0_rdy", 8'(ch_ready), 8'h03);
    run_to(230);
    check("clr0_all", 8'(all_ready), 8'h01);

    // async reset while LOCKED, between edges
    #3;
    rst_n = 1'b0;
    #1;
    chk_rst_vals("arst_lock");
    tick();
    rst_n = 1'b1;
    cyc = 0;

    // async reset mid-FILT, between edges
    run_to(8);
    check("filt_pre", 8'(pll_rst), 8'h00);
    #3;
    rst_n = 1'b0;
    #1;
    chk_rst_vals("arst_filt");
    tick();
    rst_n = 1'b1;
    cyc = 0;
    run_to(12);
    check("post_rdy_early", 8'(ch_ready), 8'h00);
    run_to(13);
    check("post_rdy", 8'(ch_ready), 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
